// File: rtl/p405s_icu_regicu_arb.sv
// ICU address register arbiter and line-fill sequencer.
// Optional round-robin arbitration when ICU_REGARB_RR_EN is defined.
module p405s_icu_regicu_arb #(
  parameter int NREQ       = 4,
  parameter int LINE_WORDS = 8,
  parameter int AW         = 32
) (
  input  logic              CB,
  input  logic              resetN,
  input  logic [0:NREQ-1]   req,
  input  logic [0:NREQ-1]   reqFill,
  input  logic [0:NREQ*AW-1] reqAddr,
  input  logic              fillBeatVal,
  input  logic              fillAbort,
  input  logic [0:AW-1]     regL2,
  output logic [0:NREQ-1]   gnt,
  output logic [0:AW-1]     regD,
  output logic              regE1,
  output logic              busy,
  output logic              fillDone
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] beat;
  logic [OW-1:0] beat_nxt;
  logic          done_nxt;
  logic          win_vld;
  logic [PW-1:0] win;
  logic [AW-1:0] sel;
  logic [AW-1:0] cur;
  logic [AW-1:0] inc;

`ifdef ICU_REGARB_RR_EN
  logic [PW-1:0] ptr;

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req[(int'(ptr) + k) % NREQ]) begin
        win_vld = 1'b1;
        win     = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      ptr <= '0;
    end else if (state == IDLE && win_vld) begin
      ptr <= (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld = 1'b1;
        win     = PW'(i);
      end
    end
  end
`endif

  // little-endian views: word offset lives just above the byte bits
  always_comb begin
    sel      = reqAddr[int'(win)*AW +: AW];
    sel[1:0] = 2'b00;
    cur      = regL2;
    inc      = cur;
    inc[OW+1:2] = cur[OW+1:2] + OW'(1);
    inc[1:0] = 2'b00;
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    done_nxt  = 1'b0;
    gnt       = '0;
    regE1     = 1'b0;
    regD      = '0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          gnt[win] = 1'b1;
          regE1    = 1'b1;
          regD     = sel;
          if (reqFill[win]) begin
            state_nxt = FILL;
            beat_nxt  = '0;
          end
        end
      end
      FILL: begin
        if (fillAbort) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
          done_nxt  = 1'b1;
        end else if (fillBeatVal) begin
          regE1    = 1'b1;
          regD     = inc;
          beat_nxt = beat + OW'(1);
          if (beat == LAST) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // grant path is combinational, so hold it quiet while in reset
    if (!resetN) begin
      gnt   = '0;
      regE1 = 1'b0;
      regD  = '0;
    end
  end

  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      beat     <= '0;
      busy     <= 1'b0;
      fillDone <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      busy     <= (state_nxt == FILL);
      fillDone <= done_nxt;
    end
  end

endmodule
